// File: rtl/pwm_pkg.sv
// Shared widths and lookup tables for the multi-channel PWM (period and duty per frequency select).
package pwm_pkg;

    localparam int SEL_W         = 3;
    localparam int CNT_W_DEFAULT = 12;
    localparam int TBL_W         = 12;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [TBL_W-1:0] tbl_t;

    localparam tbl_t PERIOD_TABLE [8] = '{
        12'd3330, 12'd2000, 12'd1330, 12'd1000, 12'd800, 12'd670, 12'd570, 12'd500
    };

    // Rows are frequency selects; columns are duty levels 1/5/10/20/40/60/80 % and period-10.
    localparam tbl_t DUTY_TABLE [8][8] = '{
        '{12'd33, 12'd167, 12'd333, 12'd666, 12'd1332, 12'd1998, 12'd2664, 12'd3320},
        '{12'd20, 12'd100, 12'd200, 12'd400, 12'd800,  12'd1200, 12'd1600, 12'd1990},
        '{12'd13, 12'd67,  12'd133, 12'd266, 12'd532,  12'd798,  12'd1064, 12'd1320},
        '{12'd10, 12'd50,  12'd100, 12'd200, 12'd400,  12'd600,  12'd800,  12'd990},
        '{12'd8,  12'd40,  12'd80,  12'd160, 12'd320,  12'd480,  12'd640,  12'd790},
        '{12'd7,  12'd34,  12'd67,  12'd134, 12'd268,  12'd402,  12'd536,  12'd660},
        '{12'd6,  12'd29,  12'd57,  12'd114, 12'd228,  12'd342,  12'd456,  12'd560},
        '{12'd5,  12'd25,  12'd50,  12'd100, 12'd200,  12'd300,  12'd400,  12'd490}
    };

    function automatic tbl_t duty_lookup(input sel_t freq, input sel_t level);
        return DUTY_TABLE[freq][level];
    endfunction

endpackage

// File: rtl/pwm_ch.sv
// One PWM channel: compare target/active registers and registered output.
// Define PWM_SOFTSTART_EN to ramp the active compare toward its target by SS_STEP per period.
module pwm_ch
    import pwm_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int SS_STEP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             advance,
    input  logic             restart,
    input  logic [CNT_W-1:0] new_target,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm_out
);

    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [CNT_W-1:0] cmp_use;
    logic             pwm_q, pwm_d;

`ifdef PWM_SOFTSTART_EN
    localparam logic [CNT_W-1:0] STEP = CNT_W'(SS_STEP);
`endif

    always_comb begin
        target_d = load ? new_target : target_q;
`ifdef PWM_SOFTSTART_EN
        cmp_d = cmp_q;
        if (advance) begin
            if (cmp_q < target_d) begin
                cmp_d = ((target_d - cmp_q) > STEP) ? cmp_q + STEP : target_d;
            end else if (cmp_q > target_d) begin
                cmp_d = ((cmp_q - target_d) > STEP) ? cmp_q - STEP : target_d;
            end
        end
`else
        cmp_d = advance ? target_d : cmp_q;
`endif
        // On a restart the counter is already at 0, so the freshly applied compare must be used now.
        cmp_use = restart ? cmp_d : cmp_q;
        pwm_d   = enable && (cnt < cmp_use);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= '0;
            cmp_q    <= '0;
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            cmp_q    <= cmp_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with a shared time base and a single-slot update handshake.
// PWM_SOFTSTART_EN (optional) enables per-channel compare ramping inside pwm_ch.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int SS_STEP = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [SEL_W-1:0]      frecuencia_in,
    input  logic [SEL_W*N_CH-1:0] corriente_in,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    output logic [N_CH-1:0]       pwm_out,
    output logic                  cycle_start
);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      period_q, period_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [SEL_W-1:0]      pend_freq_q, pend_freq_d;
    logic [SEL_W*N_CH-1:0] pend_lvl_q, pend_lvl_d;
    logic                  cycle_start_q, cycle_start_d;
    logic                  enable_q, enable_d;

    logic wrap, rise, accept, apply, advance;

    // Pending selects only become active at a period boundary or when the PWM restarts.
    always_comb begin
        wrap    = enable && (cnt_q == period_q - CNT_W'(1));
        rise    = enable && !enable_q;
        accept  = upd_valid && !pend_valid_q;
        apply   = pend_valid_q && (wrap || rise);
        advance = wrap || apply;

        cnt_d         = (!enable || wrap) ? '0 : cnt_q + CNT_W'(1);
        period_d      = apply ? CNT_W'(PERIOD_TABLE[pend_freq_q]) : period_q;
        pend_freq_d   = accept ? frecuencia_in : pend_freq_q;
        pend_lvl_d    = accept ? corriente_in : pend_lvl_q;
        cycle_start_d = enable && (cnt_q == '0);
        enable_d      = enable;

        pend_valid_d = pend_valid_q;
        if (apply) begin
            pend_valid_d = 1'b0;
        end else if (accept) begin
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            period_q      <= CNT_W'(PERIOD_TABLE[0]);
            pend_valid_q  <= 1'b0;
            pend_freq_q   <= '0;
            pend_lvl_q    <= '0;
            cycle_start_q <= 1'b0;
            enable_q      <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            pend_valid_q  <= pend_valid_d;
            pend_freq_q   <= pend_freq_d;
            pend_lvl_q    <= pend_lvl_d;
            cycle_start_q <= cycle_start_d;
            enable_q      <= enable_d;
        end
    end

    assign upd_ready   = !pend_valid_q;
    assign cycle_start = cycle_start_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] target_sel;

        assign target_sel = CNT_W'(duty_lookup(pend_freq_q, pend_lvl_q[SEL_W*i +: SEL_W]));

        pwm_ch #(
            .CNT_W  (CNT_W),
            .SS_STEP(SS_STEP)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .load      (apply),
            .advance   (advance),
            .restart   (rise),
            .new_target(target_sel),
            .cnt       (cnt_q),
            .pwm_out   (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed self-checking bench for pwm_multi_ch; the PWM_SOFTSTART_EN build runs the ramp scenario only.
module tb_pwm_multi_ch;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [2:0]  frecuenciaIn;
    logic [11:0] corrienteIn;
    logic        updValid;
    logic        updReady;
    logic [3:0]  pwmOut;
    logic        cycleStart;

    int testsRun    = 0;
    int testsFailed = 0;

    pwm_multi_ch #(
        .N_CH   (4),
        .CNT_W  (12),
        .SS_STEP(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .frecuencia_in(frecuenciaIn),
        .corriente_in (corrienteIn),
        .upd_valid    (updValid),
        .upd_ready    (updReady),
        .pwm_out      (pwmOut),
        .cycle_start  (cycleStart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [2:0] freq,
                                 input logic [11:0] lvls, input logic valid);
        reset        = rst;
        enable       = en;
        frecuenciaIn = freq;
        corrienteIn  = lvls;
        updValid     = valid;
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts on a cycle_start sample and runs up to the next one, checking length and high time.
    task automatic measurePeriod(input string tag, input int expLen,
                                 input int e0, input int e1, input int e2, input int e3);
        int len;
        int highCnt [4];
        len = 0;
        for (int c = 0; c < 4; c++) highCnt[c] = 0;
        do begin
            for (int c = 0; c < 4; c++) begin
                if (pwmOut[c]) highCnt[c]++;
            end
            len++;
            step(1);
        end while (!cycleStart && len < 5000);
        checkOutput({tag, "_len"}, len, expLen);
        checkOutput({tag, "_ch0"}, highCnt[0], e0);
        checkOutput({tag, "_ch1"}, highCnt[1], e1);
        checkOutput({tag, "_ch2"}, highCnt[2], e2);
        checkOutput({tag, "_ch3"}, highCnt[3], e3);
    endtask

    initial begin
        int readyHigh;
        int csSeen;
        int expHigh;

        applyStimulus(1'b1, 1'b0, 3'd0, 12'h000, 1'b0);
        step(3);
        checkOutput("reset_pwm", int'(pwmOut), 0);
        checkOutput("reset_cs", int'(cycleStart), 0);
        checkOutput("reset_ready", int'(updReady), 1);

`ifdef PWM_SOFTSTART_EN
        applyStimulus(1'b0, 1'b0, 3'd7, 12'b100_100_100_100, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b1, 3'd7, 12'b100_100_100_100, 1'b0);
        step(1);
        checkOutput("ramp_start_cs", int'(cycleStart), 1);
        for (int k = 1; k <= 26; k++) begin
            expHigh = (8 * k > 200) ? 200 : 8 * k;
            measurePeriod($sformatf("ramp%0d", k), 500, expHigh, expHigh, expHigh, expHigh);
        end
`else
        // Update to freq 7, level 4 while stopped, then start: 200 high out of 500.
        applyStimulus(1'b0, 1'b0, 3'd7, 12'b100_100_100_100, 1'b1);
        step(1);
        checkOutput("accept_ready", int'(updReady), 0);
        applyStimulus(1'b0, 1'b1, 3'd7, 12'b100_100_100_100, 1'b0);
        step(1);
        checkOutput("start_cs", int'(cycleStart), 1);
        checkOutput("start_pwm", int'(pwmOut), 15);
        checkOutput("start_ready", int'(updReady), 1);
        measurePeriod("f7a", 500, 200, 200, 200, 200);
        measurePeriod("f7b", 500, 200, 200, 200, 200);

        // Mid-period update to freq 3 at cnt 100, plus a second request that must be ignored.
        step(99);
        applyStimulus(1'b0, 1'b1, 3'd3, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b1);
        step(1);
        checkOutput("mid_accept_ready", int'(updReady), 0);
        applyStimulus(1'b0, 1'b1, 3'd0, 12'hFFF, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b1, 3'd0, 12'hFFF, 1'b0);
        readyHigh = 0;
        csSeen    = 0;
        for (int p = 101; p <= 498; p++) begin
            if (updReady) readyHigh++;
            if (cycleStart) csSeen++;
            step(1);
        end
        checkOutput("pending_ready_high", readyHigh, 0);
        checkOutput("pending_cs_seen", csSeen, 0);
        checkOutput("wrap_ready", int'(updReady), 1);
        checkOutput("wrap_cs", int'(cycleStart), 0);
        step(1);
        checkOutput("f3_start_cs", int'(cycleStart), 1);
        measurePeriod("f3", 1000, 10, 50, 100, 200);

        // Stop at cnt 123, queue freq 0 level 7 while stopped, then restart.
        step(122);
        applyStimulus(1'b0, 1'b0, 3'd0, 12'h000, 1'b0);
        step(1);
        checkOutput("stop_pwm", int'(pwmOut), 0);
        checkOutput("stop_cs", int'(cycleStart), 0);
        applyStimulus(1'b0, 1'b0, 3'd0, 12'hFFF, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0, 3'd0, 12'hFFF, 1'b0);
        checkOutput("stop_pending_ready", int'(updReady), 0);
        step(5);
        checkOutput("stopped_pwm", int'(pwmOut), 0);
        applyStimulus(1'b0, 1'b1, 3'd0, 12'h000, 1'b0);
        step(1);
        checkOutput("restart_cs", int'(cycleStart), 1);
        checkOutput("restart_ready", int'(updReady), 1);
        measurePeriod("f0l7", 3330, 3320, 3320, 3320, 3320);

        // Reset mid-period with a pending update: the update must be discarded.
        step(50);
        applyStimulus(1'b0, 1'b1, 3'd7, 12'b100_100_100_100, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b1, 3'd7, 12'b100_100_100_100, 1'b0);
        checkOutput("prereset_ready", int'(updReady), 0);
        applyStimulus(1'b1, 1'b1, 3'd7, 12'b100_100_100_100, 1'b0);
        step(1);
        checkOutput("midreset_pwm", int'(pwmOut), 0);
        checkOutput("midreset_cs", int'(cycleStart), 0);
        checkOutput("midreset_ready", int'(updReady), 1);
        applyStimulus(1'b0, 1'b1, 3'd7, 12'b100_100_100_100, 1'b0);
        step(1);
        checkOutput("postreset_cs", int'(cycleStart), 1);
        checkOutput("postreset_ready", int'(updReady), 1);
        measurePeriod("postreset", 3330, 0, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
